// File: rtl/audio_sigma_delta_dac.sv
// Sums all channel levels, latches the mix once per SAMPLE_DIV clocks and emits a first-order PDM stream.
// Latency: mix 1 clk, sample latch at period boundary, o_audio 2 clks after o_sample; no backpressure (free-running).
module audio_sigma_delta_dac #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_DIV   = 1024
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [9*NUM_CHANNELS-1:0]             i_channels,
  input  logic                                  i_enable,
  output logic                                  o_sample_stb,
  output logic [9+$clog2(NUM_CHANNELS)-1:0]     o_sample,
  output logic                                  o_audio
);

  localparam int SW = 9 + $clog2(NUM_CHANNELS);
  localparam int DW = $clog2(SAMPLE_DIV);

  logic [SW-1:0] mix_sum;
  logic [SW-1:0] r_sum;
  logic [DW-1:0] r_div;
  logic          div_last;
  logic [SW:0]   acc;

  // Worst case 511*NUM_CHANNELS always fits in SW bits, so no saturation is needed.
  always_comb begin
    mix_sum = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      mix_sum = mix_sum + SW'(i_channels[9*k +: 9]);
    end
  end

  assign div_last = (r_div == DW'(SAMPLE_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum        <= '0;
      r_div        <= '0;
      o_sample_stb <= 1'b0;
      o_sample     <= '0;
    end else begin
      r_sum        <= mix_sum;
      r_div        <= div_last ? '0 : r_div + DW'(1);
      o_sample_stb <= div_last;
      if (div_last) begin
        o_sample <= i_enable ? r_sum : '0;
      end
    end
  end

  // Residue in acc is kept across sample changes so the output never restarts its phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc     <= '0;
      o_audio <= 1'b0;
    end else begin
      acc     <= {1'b0, acc[SW-1:0]} + {1'b0, o_sample};
      o_audio <= acc[SW];
    end
  end

endmodule

// File: doc/audio_sigma_delta_dac.md
Name: audio_sigma_delta_dac

Overview:
Consumer end of the channel sample interface. It takes the 9-bit unsigned `o_output` level from every synthesis channel (pulse, triangle, noise, DMC) and sums them. The sum is decimated to a fixed sample rate, and a first-order sigma-delta modulator turns the held sample into a 1-bit PDM stream for the board's RC-filtered audio pin. It sits at the top level, between the channel instances and the audio output pad.

Parameters:
- NUM_CHANNELS, 4, number of 9-bit channel inputs packed into i_channels; legal 1..8.
- SAMPLE_DIV, 1024, i_clk cycles per output sample period; legal >= 2.
- SW (localparam), 9+$clog2(NUM_CHANNELS), mix/sample width; 11 at default.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_channels  input  9*NUM_CHANNELS  packed channel levels; channel k is at [9k+8:9k]; unsigned.
- i_enable  input  1  1 = normal; 0 = mute (zero is latched at the next sample boundary).
- o_sample_stb  output  1  one-cycle pulse marking each sample-latch edge.
- o_sample  output  SW  currently held mixed sample, unsigned.
- o_audio  output  1  registered PDM bitstream.

Behaviour:
- Reset is asynchronous and active-low: one clock, `i_clk`; asynchronous active-low reset `i_rst_n`. Assertion immediately clears r_div, r_sum, o_sample, the accumulator, o_sample_stb and o_audio to 0. Operation resumes on the first i_clk edge after release, with r_div = 0.
- Mix stage:
  - r_sum <= sum of all NUM_CHANNELS inputs, registered every clock, zero-extended to SW bits.
  - r_sum never overflows: the maximum is 511*NUM_CHANNELS < 2^SW.
  - Latency is 1 clock.
- Divider:
  - r_div counts 0..SAMPLE_DIV-1 and wraps to 0.
  - o_sample_stb (registered) is 1 for exactly the cycle after r_div == SAMPLE_DIV-1. Period is SAMPLE_DIV clocks.
  - The first strobe is the SAMPLE_DIV-th clock edge after reset release.
- Sample latch:
  - On the edge where r_div == SAMPLE_DIV-1, o_sample <= (i_enable ? r_sum : 0).
  - o_sample changes on the same edge that raises o_sample_stb. It is held constant for the entire period.
  - i_enable is sampled only at that edge; toggling it mid-period has no effect until the next boundary.
- Modulator:
  - Accumulator acc is SW+1 bits.
  - Every clock: acc <= {1'b0, acc[SW-1:0]} + {1'b0, o_sample}; o_audio <= acc[SW] (the carry out).
  - With o_sample held at S, exactly S ones occur in any 2^SW consecutive o_audio bits once steady state is reached (after 2 clocks).
  - S = 0 produces a constant 0. The residue acc[SW-1:0] is not cleared at sample boundaries, so there is no pop or phase reset.
- Boundary conditions:
  - SAMPLE_DIV = 2 gives a strobe every other cycle.
  - Channel inputs are unconstrained and may change every clock; only r_sum at the latch edge matters.
  - Reset asserted mid-period aborts the period with no partial strobe.

Test Plan:
- Reset: hold i_rst_n low, drive all channels 511 -> o_audio, o_sample, o_sample_stb all 0. Assert reset mid-stream -> all outputs 0 before the next clock edge.
- Strobe timing (SAMPLE_DIV=16): release reset -> o_sample_stb high on clock edges 16, 32, 48, each for one cycle; never high elsewhere.
- Single noise-level channel: ch2 = 9'h0B, others 0, enable = 1 -> o_sample = 11 after the first strobe; exactly 11 ones per 2048 consecutive o_audio bits.
- Full scale: all four channels 511 -> o_sample = 2044; 2044 ones per 2048 bits. All channels 0 -> o_audio constant 0.
- Mute: i_enable dropped mid-period with ch0 = 100 -> o_sample stays 100 until the next strobe, then 0. o_audio goes constant 0 after at most 2^SW further clocks (residue drain); re-enable restores 100 at the following boundary.
- Mid-period input change: ch0 toggles 0 <-> 511 every clock -> o_sample equals r_sum as captured at the latch edge (value from 1 cycle before), stable for the whole period.
